avr_xbus_bridge: RTL and testbench

- Downstream slave of the AVR core's external data-memory window; consumes the core's sram_* strobes.
- Converts single-cycle AVR SRAM-window accesses into a registered req/ack bus toward slow peripherals: GD-ROM register file, sector buffer.
- Reads stall the core through sram_wait until the target acks.
- Writes are posted into a 1-deep buffer so the core normally sees zero wait states.

---
 rtl/avr_xbus_bridge_if.sv | 36 +++
 rtl/avr_xbus_bridge.sv | 160 ++++++++++++++++
 tb/tb_avr_xbus_bridge.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/avr_xbus_bridge_if.sv
// rtl/avr_xbus_bridge_if.sv - AVR SRAM-window and peripheral req/ack bus signal bundle
interface avr_xbus_bridge_if #(
  parameter int ADDR_WIDTH = 10
);
  // AVR core side
  logic [15:0]           sram_a;
  logic [7:0]            sram_d_out;
  logic                  sram_cs;
  logic                  sram_oe;
  logic                  sram_we;
  logic [7:0]            sram_d_in;
  logic                  sram_wait;
  // peripheral bus side
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [7:0]            bus_wdata;
  logic                  bus_we;
  logic                  bus_req;
  logic [7:0]            bus_rdata;
  logic                  bus_ack;

  // bridge view: slave of the AVR window, initiator on the peripheral bus
  modport slave (
    input  sram_a, sram_d_out, sram_cs, sram_oe, sram_we,
    output sram_d_in, sram_wait,
    output bus_addr, bus_wdata, bus_we, bus_req,
    input  bus_rdata, bus_ack
  );

  // environment view: AVR core plus peripheral targets
  modport master (
    output sram_a, sram_d_out, sram_cs, sram_oe, sram_we,
    input  sram_d_in, sram_wait,
    input  bus_addr, bus_wdata, bus_we, bus_req,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/avr_xbus_bridge.sv
// rtl/avr_xbus_bridge.sv - AVR SRAM window to registered req/ack bus bridge (optional timeout: AVR_XBUS_TIMEOUT_EN)
module avr_xbus_bridge #(
  parameter int         ADDR_WIDTH     = 10,
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [7:0] TMO_RDATA      = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  avr_xbus_bridge_if.slave  xb,
  output logic              err_sticky,
  input  logic              err_clr
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_RD_DONE = 2'd2,
    S_WR_BUSY = 2'd3
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic [7:0]            r_bus_wdata;
  logic                  r_bus_we;
  logic                  r_bus_req;
  logic [7:0]            r_rd_latch;

  logic                  w_rd;
  logic                  w_wr;
  logic                  w_wait;

  // a write and a read in the same cycle is illegal; the write wins
  assign w_rd = xb.sram_cs & xb.sram_oe & ~w_wr;
  assign w_wr = xb.sram_cs & xb.sram_we;

`ifdef AVR_XBUS_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;
  logic        r_err_sticky;
  logic        w_busy;
  logic        w_expire;

  assign w_busy   = (r_state == S_RD_WAIT) || (r_state == S_WR_BUSY);
  // an ack arriving in the expiry cycle is a normal completion
  assign w_expire = w_busy && !xb.bus_ack && (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  // cycle counter: zero in the first outstanding cycle, counts while a request waits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= 16'd0;
    end else if (w_busy) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end else begin
      r_tmo_cnt <= 16'd0;
    end
  end

  // sticky timeout flag; a timeout in the same cycle as a clear keeps it set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_sticky <= 1'b0;
    end else if (w_expire) begin
      r_err_sticky <= 1'b1;
    end else if (err_clr) begin
      r_err_sticky <= 1'b0;
    end
  end

  assign err_sticky = r_err_sticky;

  logic w_unused;
  assign w_unused = ^xb.sram_a[15:ADDR_WIDTH];
`else
  // without the timeout a missing ack stalls the core until reset
  assign err_sticky = 1'b0;

  logic w_unused;
  assign w_unused = ^{xb.sram_a[15:ADDR_WIDTH], err_clr, TMO_RDATA, 16'(TIMEOUT_CYCLES)};
`endif

  // bridge FSM: posts writes, stalls reads until the target answers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bus_addr  <= '0;
      r_bus_wdata <= 8'd0;
      r_bus_we    <= 1'b0;
      r_bus_req   <= 1'b0;
      r_rd_latch  <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr) begin
            r_bus_addr  <= xb.sram_a[ADDR_WIDTH-1:0];
            r_bus_wdata <= xb.sram_d_out;
            r_bus_we    <= 1'b1;
            r_bus_req   <= 1'b1;
            r_state     <= S_WR_BUSY;
          end else if (w_rd) begin
            r_bus_addr  <= xb.sram_a[ADDR_WIDTH-1:0];
            r_bus_we    <= 1'b0;
            r_bus_req   <= 1'b1;
            r_state     <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (xb.bus_ack) begin
            r_rd_latch <= xb.bus_rdata;
            r_bus_req  <= 1'b0;
            r_state    <= S_RD_DONE;
          end
`ifdef AVR_XBUS_TIMEOUT_EN
          else if (w_expire) begin
            r_rd_latch <= TMO_RDATA;
            r_bus_req  <= 1'b0;
            r_state    <= S_RD_DONE;
          end
`endif
        end
        S_RD_DONE: begin
          r_state <= S_IDLE;
        end
        S_WR_BUSY: begin
          if (xb.bus_ack) begin
            r_bus_req <= 1'b0;
            r_state   <= S_IDLE;
          end
`ifdef AVR_XBUS_TIMEOUT_EN
          else if (w_expire) begin
            r_bus_req <= 1'b0;
            r_state   <= S_IDLE;
          end
`endif
        end
        default: begin
          r_state   <= S_IDLE;
          r_bus_req <= 1'b0;
        end
      endcase
    end
  end

  // core stall: reads wait for data, anything behind a posted write waits for it
  always_comb begin
    w_wait = 1'b0;
    case (r_state)
      S_IDLE:    w_wait = w_rd;
      S_RD_WAIT: w_wait = 1'b1;
      S_WR_BUSY: w_wait = w_rd | w_wr;
      default:   w_wait = 1'b0;
    endcase
  end

  assign xb.sram_wait = w_wait;
  assign xb.sram_d_in = r_rd_latch;
  assign xb.bus_addr  = r_bus_addr;
  assign xb.bus_wdata = r_bus_wdata;
  assign xb.bus_we    = r_bus_we;
  assign xb.bus_req   = r_bus_req;

endmodule

// File: tb/tb_avr_xbus_bridge.sv
// tb/tb_avr_xbus_bridge.sv - directed self-checking bench for avr_xbus_bridge
module tb_avr_xbus_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_clr = 1'b0;
  logic err_sticky;

  avr_xbus_bridge_if #(.ADDR_WIDTH(10)) xb ();

  avr_xbus_bridge #(
    .ADDR_WIDTH(10),
    .TIMEOUT_CYCLES(8),
    .TMO_RDATA(8'hFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .xb(xb),
    .err_sticky(err_sticky),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // target model: acks in req cycle 'lat' (0 = first req cycle); lat < 0 never acks
  int         lat = 0;
  logic [7:0] rsp_data = 8'h00;
  logic       force_ack = 1'b0;
  logic [9:0] log_addr [16];
  logic [7:0] log_wdata [16];
  logic       log_we [16];
  int         log_n = 0;
  int         hold_err = 0;

  initial begin
    int         cnt;
    logic       prev_req;
    logic [9:0] h_addr;
    logic [7:0] h_wdata;
    logic       h_we;
    cnt = 0;
    prev_req = 1'b0;
    h_addr = '0;
    h_wdata = '0;
    h_we = 1'b0;
    xb.bus_ack = 1'b0;
    xb.bus_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      xb.bus_ack = 1'b0;
      if (xb.bus_req) begin
        if (prev_req && (xb.bus_addr !== h_addr || xb.bus_wdata !== h_wdata || xb.bus_we !== h_we))
          hold_err++;
        h_addr = xb.bus_addr;
        h_wdata = xb.bus_wdata;
        h_we = xb.bus_we;
        if (lat >= 0 && cnt == lat) begin
          xb.bus_ack = 1'b1;
          xb.bus_rdata = rsp_data;
          if (log_n < 16) begin
            log_addr[log_n] = xb.bus_addr;
            log_wdata[log_n] = xb.bus_wdata;
            log_we[log_n] = xb.bus_we;
          end
          log_n++;
        end
        cnt++;
      end else begin
        cnt = 0;
      end
      if (force_ack) begin
        xb.bus_ack = 1'b1;
        force_ack = 1'b0;
      end
      prev_req = xb.bus_req;
    end
  end

  // one core access, entered and left at posedge+1; stalls counts sram_wait cycles
  task automatic core_access(input logic w, input logic [15:0] a, input logic [7:0] d,
                             output logic [7:0] q, output int stalls);
    xb.sram_a = a;
    xb.sram_d_out = d;
    xb.sram_cs = 1'b1;
    xb.sram_oe = ~w;
    xb.sram_we = w;
    stalls = 0;
    #1;
    while (xb.sram_wait && stalls < 200) begin
      stalls++;
      @(posedge clk);
      #2;
    end
    q = xb.sram_d_in;
    @(posedge clk);
    #1;
    xb.sram_cs = 1'b0;
    xb.sram_oe = 1'b0;
    xb.sram_we = 1'b0;
  endtask

  task automatic wait_bus_idle();
    for (int i = 0; i < 100 && xb.bus_req; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("bus_idle", 32'(xb.bus_req), 32'd0);
  endtask

  logic [7:0] q;
  int         st;

  initial begin
    xb.sram_a = 16'h0000;
    xb.sram_d_out = 8'h00;
    xb.sram_cs = 1'b0;
    xb.sram_oe = 1'b0;
    xb.sram_we = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    check_eq("rst_wait", 32'(xb.sram_wait), 32'd0);
    check_eq("rst_req", 32'(xb.bus_req), 32'd0);
    check_eq("rst_we", 32'(xb.bus_we), 32'd0);
    check_eq("rst_addr", 32'(xb.bus_addr), 32'd0);
    check_eq("rst_wdata", 32'(xb.bus_wdata), 32'd0);
    check_eq("rst_err", 32'(err_sticky), 32'd0);
    check_eq("rst_d_in", 32'(xb.sram_d_in), 32'd0);

    // read, ack three cycles after the first req cycle: 1 + 4 stall cycles
    lat = 3;
    rsp_data = 8'hA5;
    core_access(1'b0, 16'hE012, 8'h00, q, st);
    check_eq("rd_stalls", 32'(st), 32'd5);
    check_eq("rd_data", 32'(q), 32'hA5);
    check_eq("rd_addr", 32'(log_addr[0]), 32'h012);
    check_eq("rd_we", 32'(log_we[0]), 32'd0);
    @(posedge clk);
    #1;
    check_eq("rd_d_in_stable", 32'(xb.sram_d_in), 32'hA5);

    // posted write: zero wait for the core, fields held until ack
    lat = 4;
    core_access(1'b1, 16'hE004, 8'h3C, q, st);
    check_eq("wr_stalls", 32'(st), 32'd0);
    check_eq("wr_req_pending", 32'(xb.bus_req), 32'd1);
    wait_bus_idle();
    check_eq("wr_addr", 32'(log_addr[1]), 32'h004);
    check_eq("wr_wdata", 32'(log_wdata[1]), 32'h3C);
    check_eq("wr_we", 32'(log_we[1]), 32'd1);

    // write then read: 3 cycles behind the write, 1 in IDLE, 3 for the read
    lat = 2;
    rsp_data = 8'h77;
    core_access(1'b1, 16'hE008, 8'h55, q, st);
    check_eq("wrrd_wr_stalls", 32'(st), 32'd0);
    core_access(1'b0, 16'hE009, 8'h00, q, st);
    check_eq("wrrd_rd_stalls", 32'(st), 32'd7);
    check_eq("wrrd_rd_data", 32'(q), 32'h77);
    check_eq("wrrd_order0", {21'd0, log_we[2], log_addr[2]}, {21'd0, 1'b1, 10'h008});
    check_eq("wrrd_order1", {21'd0, log_we[3], log_addr[3]}, {21'd0, 1'b0, 10'h009});

    // back-to-back writes: second stalls for the whole first transaction
    lat = 2;
    core_access(1'b1, 16'hE020, 8'h11, q, st);
    check_eq("b2b_w1_stalls", 32'(st), 32'd0);
    core_access(1'b1, 16'hE021, 8'h22, q, st);
    check_eq("b2b_w2_stalls", 32'(st), 32'd3);
    wait_bus_idle();
    check_eq("b2b_first", {22'd0, log_addr[4]}, 32'h020);
    check_eq("b2b_first_d", 32'(log_wdata[4]), 32'h11);
    check_eq("b2b_second", {22'd0, log_addr[5]}, 32'h021);
    check_eq("b2b_second_d", 32'(log_wdata[5]), 32'h22);

    // ack in the first req cycle: minimum read cost of two stalls
    lat = 0;
    rsp_data = 8'h5A;
    core_access(1'b0, 16'hE3FF, 8'h00, q, st);
    check_eq("rd_fast_stalls", 32'(st), 32'd2);
    check_eq("rd_fast_data", 32'(q), 32'h5A);
    check_eq("rd_fast_addr", 32'(log_addr[6]), 32'h3FF);
    check_eq("hold_stable", 32'(hold_err), 32'd0);
    check_eq("log_count", 32'(log_n), 32'd7);

    // stray ack while idle must be ignored
    force_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("stray_req", 32'(xb.bus_req), 32'd0);
    check_eq("stray_d_in", 32'(xb.sram_d_in), 32'h5A);
    check_eq("stray_wait", 32'(xb.sram_wait), 32'd0);

`ifdef AVR_XBUS_TIMEOUT_EN
    // read with no ack: 1 IDLE stall + 8 req cycles, then timeout data
    lat = -1;
    core_access(1'b0, 16'hE030, 8'h00, q, st);
    check_eq("tmo_stalls", 32'(st), 32'd9);
    check_eq("tmo_data", 32'(q), 32'hFF);
    check_eq("tmo_req", 32'(xb.bus_req), 32'd0);
    check_eq("tmo_err", 32'(err_sticky), 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check_eq("tmo_err_clr", 32'(err_sticky), 32'd0);
`else
    check_eq("err_tied_low", 32'(err_sticky), 32'd0);
`endif

    // reset during an outstanding read drops bus_req without a clock edge
    lat = -1;
    xb.sram_a = 16'hE040;
    xb.sram_cs = 1'b1;
    xb.sram_oe = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("midrst_req_before", 32'(xb.bus_req), 32'd1);
    check_eq("midrst_wait_before", 32'(xb.sram_wait), 32'd1);
    xb.sram_cs = 1'b0;
    xb.sram_oe = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_req_async", 32'(xb.bus_req), 32'd0);
    check_eq("midrst_wait", 32'(xb.sram_wait), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_addr", 32'(xb.bus_addr), 32'd0);
    check_eq("midrst_d_in", 32'(xb.sram_d_in), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
